// File: rtl/local_sink.sv
// Ejection-port traffic sink for one mesh node: registers arriving flits, classifies them,
// tracks per-source sequence numbers and keeps saturating delivery/latency statistics.
module local_sink #(
  parameter int DATAWID = 32,
  parameter int MY_X    = 0,
  parameter int MY_Y    = 0,
  parameter int CNT_W   = 16,
  parameter int SUM_W   = 24
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [DATAWID-1:0] flit_in,
  input  logic [14:0]        time_now,
  input  logic               en,
  input  logic               clr,
  input  logic [2:0]         stat_sel,
  output logic [SUM_W-1:0]   stat_out,
  output logic [CNT_W-1:0]   rx_count,
  output logic               rx_pulse,
  output logic [3:0]         last_src,
  output logic               err_flag
);

  localparam int         NSRC = 9;
  localparam logic [1:0] MYX  = 2'(MY_X);
  localparam logic [1:0] MYY  = 2'(MY_Y);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  // S0: header bits [30:15] and the latency measured in the arrival cycle
  logic        s0_vld_q, s0_vld_d;
  logic [15:0] s0_hdr_q, s0_hdr_d;
  logic [14:0] s0_lat_q, s0_lat_d;

  // S1: decoded class and the (forwarded) sequence check result
  logic        s1_vld_q, s1_bad_q, s1_mis_q, s1_serr_q;
  logic [3:0]  s1_src_q;
  logic [7:0]  s1_seq_q;
  logic [14:0] s1_lat_q;

  logic        dec_bad_s, dec_mis_s, dec_serr_s, fwd_hit_s;
  logic        tbl_seen_s, eff_seen_s;
  logic [7:0]  tbl_exp_s, eff_exp_s, dec_seq_s;
  logic [3:0]  dec_src_s;

  logic [CNT_W-1:0] rx_cnt_q, rx_cnt_d, mis_cnt_q, mis_cnt_d;
  logic [CNT_W-1:0] serr_cnt_q, serr_cnt_d, bad_cnt_q, bad_cnt_d;
  logic [14:0]      lat_max_q, lat_max_d, lat_last_q, lat_last_d;
  logic [SUM_W-1:0] lat_sum_q, lat_sum_d, stat_q, stat_d;
  logic [SUM_W:0]   sum_s;
  logic [NSRC-1:0]  seen_q, seen_d;
  logic [7:0]       exp_q [NSRC];
  logic [7:0]       exp_d [NSRC];
  logic             err_q, err_d, pulse_q, pulse_d;
  logic [3:0]       last_src_q, last_src_d;

  // Capture and decode stages, including forwarding of the S2 table update
  always_comb begin
    s0_vld_d  = flit_in[31];
    s0_hdr_d  = flit_in[31] ? flit_in[30:15] : s0_hdr_q;
    s0_lat_d  = time_now - flit_in[14:0];
    dec_bad_s = (s0_hdr_q[11:10] == 2'd3) || (s0_hdr_q[9:8] == 2'd3);
    dec_mis_s = !dec_bad_s && ((s0_hdr_q[15:14] != MYX) || (s0_hdr_q[13:12] != MYY));
    dec_src_s = ({2'b00, s0_hdr_q[9:8]} * 4'd3) + {2'b00, s0_hdr_q[11:10]};
    dec_seq_s = s0_hdr_q[7:0];
    fwd_hit_s = s1_vld_q && en && !s1_bad_q && !s1_mis_q && (s1_src_q == dec_src_s);
    if (dec_src_s < 4'(NSRC)) begin
      tbl_seen_s = seen_q[dec_src_s];
      tbl_exp_s  = exp_q[dec_src_s];
    end else begin
      tbl_seen_s = 1'b0;
      tbl_exp_s  = 8'd0;
    end
    if (clr) begin
      eff_seen_s = 1'b0;
      eff_exp_s  = 8'd0;
    end else if (fwd_hit_s) begin
      eff_seen_s = 1'b1;
      eff_exp_s  = s1_seq_q + 8'd1;
    end else begin
      eff_seen_s = tbl_seen_s;
      eff_exp_s  = tbl_exp_s;
    end
    dec_serr_s = !dec_bad_s && !dec_mis_s && eff_seen_s && (dec_seq_s != eff_exp_s);
  end

  // Pipeline registers for S0 and S1
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s0_vld_q  <= 1'b0;
      s0_hdr_q  <= 16'd0;
      s0_lat_q  <= 15'd0;
      s1_vld_q  <= 1'b0;
      s1_bad_q  <= 1'b0;
      s1_mis_q  <= 1'b0;
      s1_serr_q <= 1'b0;
      s1_src_q  <= 4'd0;
      s1_seq_q  <= 8'd0;
      s1_lat_q  <= 15'd0;
    end else begin
      s0_vld_q  <= s0_vld_d;
      s0_hdr_q  <= s0_hdr_d;
      s0_lat_q  <= s0_lat_d;
      s1_vld_q  <= s0_vld_q;
      s1_bad_q  <= dec_bad_s;
      s1_mis_q  <= dec_mis_s;
      s1_serr_q <= dec_serr_s;
      s1_src_q  <= dec_src_s;
      s1_seq_q  <= dec_seq_s;
      s1_lat_q  <= s0_lat_q;
    end
  end

  // S2 statistics update and registered statistic select
  always_comb begin
    rx_cnt_d   = rx_cnt_q;
    mis_cnt_d  = mis_cnt_q;
    serr_cnt_d = serr_cnt_q;
    bad_cnt_d  = bad_cnt_q;
    lat_max_d  = lat_max_q;
    lat_last_d = lat_last_q;
    lat_sum_d  = lat_sum_q;
    seen_d     = seen_q;
    exp_d      = exp_q;
    err_d      = err_q;
    pulse_d    = 1'b0;
    last_src_d = last_src_q;
    sum_s      = {1'b0, lat_sum_q} + (SUM_W+1)'(s1_lat_q);
    if (clr) begin
      rx_cnt_d   = {CNT_W{1'b0}};
      mis_cnt_d  = {CNT_W{1'b0}};
      serr_cnt_d = {CNT_W{1'b0}};
      bad_cnt_d  = {CNT_W{1'b0}};
      lat_max_d  = 15'd0;
      lat_last_d = 15'd0;
      lat_sum_d  = {SUM_W{1'b0}};
      seen_d     = {NSRC{1'b0}};
      for (int i = 0; i < NSRC; i++) exp_d[i] = 8'd0;
      err_d      = 1'b0;
    end else if (en && s1_vld_q) begin
      if (s1_bad_q) begin
        bad_cnt_d = sat_inc(bad_cnt_q);
        err_d     = 1'b1;
      end else if (s1_mis_q) begin
        mis_cnt_d = sat_inc(mis_cnt_q);
        err_d     = 1'b1;
      end else begin
        rx_cnt_d         = sat_inc(rx_cnt_q);
        pulse_d          = 1'b1;
        last_src_d       = s1_src_q;
        lat_sum_d        = sum_s[SUM_W] ? {SUM_W{1'b1}} : sum_s[SUM_W-1:0];
        lat_max_d        = (s1_lat_q > lat_max_q) ? s1_lat_q : lat_max_q;
        lat_last_d       = s1_lat_q;
        seen_d[s1_src_q] = 1'b1;
        exp_d[s1_src_q]  = s1_seq_q + 8'd1;
        if (s1_serr_q) begin
          serr_cnt_d = sat_inc(serr_cnt_q);
          err_d      = 1'b1;
        end else begin
          serr_cnt_d = serr_cnt_q;
        end
      end
    end else begin
      pulse_d = 1'b0;
    end
    case (stat_sel)
      3'd0:    stat_d = SUM_W'(rx_cnt_q);
      3'd1:    stat_d = SUM_W'(mis_cnt_q);
      3'd2:    stat_d = SUM_W'(serr_cnt_q);
      3'd3:    stat_d = SUM_W'(bad_cnt_q);
      3'd4:    stat_d = SUM_W'(lat_max_q);
      3'd5:    stat_d = lat_sum_q;
      3'd6:    stat_d = SUM_W'(lat_last_q);
      default: stat_d = {SUM_W{1'b0}};
    endcase
  end

  // Statistics, sequence table and output registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rx_cnt_q   <= {CNT_W{1'b0}};
      mis_cnt_q  <= {CNT_W{1'b0}};
      serr_cnt_q <= {CNT_W{1'b0}};
      bad_cnt_q  <= {CNT_W{1'b0}};
      lat_max_q  <= 15'd0;
      lat_last_q <= 15'd0;
      lat_sum_q  <= {SUM_W{1'b0}};
      seen_q     <= {NSRC{1'b0}};
      for (int i = 0; i < NSRC; i++) exp_q[i] <= 8'd0;
      err_q      <= 1'b0;
      pulse_q    <= 1'b0;
      last_src_q <= 4'd0;
      stat_q     <= {SUM_W{1'b0}};
    end else begin
      rx_cnt_q   <= rx_cnt_d;
      mis_cnt_q  <= mis_cnt_d;
      serr_cnt_q <= serr_cnt_d;
      bad_cnt_q  <= bad_cnt_d;
      lat_max_q  <= lat_max_d;
      lat_last_q <= lat_last_d;
      lat_sum_q  <= lat_sum_d;
      seen_q     <= seen_d;
      exp_q      <= exp_d;
      err_q      <= err_d;
      pulse_q    <= pulse_d;
      last_src_q <= last_src_d;
      stat_q     <= stat_d;
    end
  end

  assign stat_out = stat_q;
  assign rx_count = rx_cnt_q;
  assign rx_pulse = pulse_q;
  assign last_src = last_src_q;
  assign err_flag = err_q;

endmodule

// File: tb/tb_local_sink.sv
// Directed bench for local_sink at node (1,1); a second narrow instance exercises saturation.
module tb_local_sink;

  logic        clk = 1'b0;
  logic        reset, en, clr;
  logic [31:0] flit_in;
  logic [14:0] time_now;
  logic [2:0]  stat_sel;
  logic [23:0] stat_out;
  logic [15:0] rx_count;
  logic        rx_pulse, err_flag;
  logic [3:0]  last_src;
  logic [15:0] s_stat_out;
  logic [3:0]  s_rx_count, s_last_src;
  logic        s_rx_pulse, s_err_flag;
  int          n_chk = 0;
  int          n_pass = 0;
  logic [23:0] exp_tab [8];
  logic [23:0] prev_v;

  always #5 clk = ~clk;

  local_sink #(.DATAWID(32), .MY_X(1), .MY_Y(1), .CNT_W(16), .SUM_W(24)) u_dut (
    .clk(clk), .reset(reset), .flit_in(flit_in), .time_now(time_now), .en(en), .clr(clr),
    .stat_sel(stat_sel), .stat_out(stat_out), .rx_count(rx_count), .rx_pulse(rx_pulse),
    .last_src(last_src), .err_flag(err_flag));

  local_sink #(.DATAWID(32), .MY_X(1), .MY_Y(1), .CNT_W(4), .SUM_W(16)) u_sat (
    .clk(clk), .reset(reset), .flit_in(flit_in), .time_now(time_now), .en(en), .clr(clr),
    .stat_sel(stat_sel), .stat_out(s_stat_out), .rx_count(s_rx_count), .rx_pulse(s_rx_pulse),
    .last_src(s_last_src), .err_flag(s_err_flag));

  function automatic logic [31:0] mk(input logic [1:0] dx, input logic [1:0] dy,
                                     input logic [1:0] sx, input logic [1:0] sy,
                                     input logic [7:0] seq, input logic [14:0] ts);
    return {1'b1, dx, dy, sx, sy, seq, ts};
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic drive(input logic [31:0] f, input logic [14:0] t);
    flit_in  = f;
    time_now = t;
    @(posedge clk);
    #1;
    flit_in  = 32'd0;
    time_now = 15'd0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk_stat(input string tag, input logic [2:0] sel, input logic [23:0] exp);
    stat_sel = sel;
    idle(1);
    check(tag, 32'(stat_out), 32'(exp));
  endtask

  task automatic pulse_clr();
    clr = 1'b1;
    idle(1);
    clr = 1'b0;
  endtask

  initial begin
    reset = 1'b0; en = 1'b1; clr = 1'b0; stat_sel = 3'd0;
    flit_in = 32'd0; time_now = 15'd0;
    #12;
    check("rst_rx_count", 32'(rx_count), 32'd0);
    check("rst_rx_pulse", 32'(rx_pulse), 32'd0);
    check("rst_last_src", 32'(last_src), 32'd0);
    check("rst_err_flag", 32'(err_flag), 32'd0);
    check("rst_stat_out", 32'(stat_out), 32'd0);
    check("rst_sat_misc", {25'd0, s_rx_pulse, s_err_flag, s_last_src, 1'b0}, 32'd0);
    reset = 1'b1;
    idle(1);

    // single flit, latency 0x25-0x10 = 21
    drive(32'hA8000010, 15'h25);
    idle(1);
    check("t1_pulse_early", 32'(rx_pulse), 32'd0);
    idle(1);
    check("t1_pulse", 32'(rx_pulse), 32'd1);
    check("t1_rx_count", 32'(rx_count), 32'd1);
    check("t1_last_src", 32'(last_src), 32'd0);
    check("t1_err", 32'(err_flag), 32'd0);
    idle(1);
    check("t1_pulse_once", 32'(rx_pulse), 32'd0);
    chk_stat("t1_lat_last", 3'd6, 24'd21);
    chk_stat("t1_lat_max", 3'd4, 24'd21);

    // back-to-back from src (2,1), in sequence
    for (int i = 0; i < 4; i++) drive(mk(2'd1, 2'd1, 2'd2, 2'd1, 8'(i), 15'd0), 15'd0);
    idle(2);
    check("b2b_rx_count", 32'(rx_count), 32'd5);
    check("b2b_last_src", 32'(last_src), 32'd5);
    check("b2b_err", 32'(err_flag), 32'd0);
    chk_stat("b2b_seq_err", 3'd2, 24'd0);

    // skipped sequence number after clear
    pulse_clr();
    check("clr_rx_count", 32'(rx_count), 32'd0);
    drive(mk(2'd1, 2'd1, 2'd2, 2'd1, 8'd0, 15'd0), 15'd0);
    drive(mk(2'd1, 2'd1, 2'd2, 2'd1, 8'd1, 15'd0), 15'd0);
    drive(mk(2'd1, 2'd1, 2'd2, 2'd1, 8'd3, 15'd0), 15'd0);
    idle(2);
    chk_stat("skip_seq_err", 3'd2, 24'd1);
    check("skip_err", 32'(err_flag), 32'd1);
    check("skip_rx_count", 32'(rx_count), 32'd3);
    drive(mk(2'd1, 2'd1, 2'd2, 2'd1, 8'd4, 15'd0), 15'd0);
    idle(2);
    chk_stat("resync_seq_err", 3'd2, 24'd1);
    check("resync_rx_count", 32'(rx_count), 32'd4);

    // misroute and bad address
    pulse_clr();
    drive(mk(2'd0, 2'd2, 2'd0, 2'd0, 8'd0, 15'd0), 15'd0);
    idle(2);
    check("mis_no_pulse", 32'(rx_pulse), 32'd0);
    check("mis_rx_count", 32'(rx_count), 32'd0);
    check("mis_err", 32'(err_flag), 32'd1);
    chk_stat("mis_cnt", 3'd1, 24'd1);
    drive(mk(2'd1, 2'd1, 2'd3, 2'd0, 8'd0, 15'd0), 15'd0);
    idle(2);
    chk_stat("bad_cnt", 3'd3, 24'd1);
    chk_stat("bad_not_mis", 3'd1, 24'd1);
    check("bad_rx_count", 32'(rx_count), 32'd0);

    // latency wrap: (0x0005 - 0x7FF0) mod 2^15 = 21, then latency 100
    pulse_clr();
    drive(mk(2'd1, 2'd1, 2'd2, 2'd2, 8'd0, 15'h7FF0), 15'h0005);
    idle(2);
    check("wrap_last_src", 32'(last_src), 32'd8);
    chk_stat("wrap_lat_last", 3'd6, 24'd21);
    drive(mk(2'd1, 2'd1, 2'd2, 2'd2, 8'd1, 15'd0), 15'd100);
    idle(2);
    check("wrap_err", 32'(err_flag), 32'd0);

    // stat_sel sweep with one-cycle read latency
    exp_tab = '{24'd2, 24'd0, 24'd0, 24'd0, 24'd100, 24'd121, 24'd100, 24'd0};
    stat_sel = 3'd7;
    idle(1);
    prev_v = 24'd0;
    for (int s = 0; s < 8; s++) begin
      stat_sel = 3'(s);
      #2;
      check("sel_hold", 32'(stat_out), 32'(prev_v));
      idle(1);
      check("sel_new", 32'(stat_out), 32'(exp_tab[s]));
      prev_v = exp_tab[s];
    end

    // en=0: nothing changes, including the sequence table
    en = 1'b0;
    drive(mk(2'd1, 2'd1, 2'd2, 2'd2, 8'd9, 15'd0), 15'd7);
    drive(mk(2'd1, 2'd1, 2'd2, 2'd2, 8'd5, 15'd0), 15'd7);
    drive(mk(2'd0, 2'd0, 2'd2, 2'd2, 8'd5, 15'd0), 15'd7);
    drive(mk(2'd1, 2'd1, 2'd3, 2'd3, 8'd5, 15'd0), 15'd7);
    drive(mk(2'd1, 2'd1, 2'd0, 2'd0, 8'd5, 15'd0), 15'd7);
    idle(3);
    check("en0_rx_count", 32'(rx_count), 32'd2);
    check("en0_err", 32'(err_flag), 32'd0);
    chk_stat("en0_mis", 3'd1, 24'd0);
    chk_stat("en0_lat_sum", 3'd5, 24'd121);
    en = 1'b1;
    drive(mk(2'd1, 2'd1, 2'd2, 2'd2, 8'd2, 15'd0), 15'd0);
    idle(2);
    check("en1_rx_count", 32'(rx_count), 32'd3);
    chk_stat("en1_seq_err", 3'd2, 24'd0);

    // clr on the same edge as an S2 update; the following flit still lands
    drive(mk(2'd1, 2'd1, 2'd0, 2'd0, 8'd0, 15'd0), 15'd50);
    drive(mk(2'd1, 2'd1, 2'd0, 2'd0, 8'd1, 15'd0), 15'd30);
    clr = 1'b1;
    idle(1);
    clr = 1'b0;
    check("clr_ovr_rx_count", 32'(rx_count), 32'd0);
    check("clr_ovr_pulse", 32'(rx_pulse), 32'd0);
    idle(1);
    check("clr_next_pulse", 32'(rx_pulse), 32'd1);
    check("clr_next_rx_count", 32'(rx_count), 32'd1);
    chk_stat("clr_lat_max", 3'd4, 24'd30);
    chk_stat("clr_lat_sum", 3'd5, 24'd30);
    chk_stat("clr_seq_err", 3'd2, 24'd0);

    // saturation on the narrow instance (CNT_W=4, SUM_W=16)
    pulse_clr();
    for (int i = 0; i < 17; i++) drive(mk(2'd1, 2'd1, 2'd0, 2'd0, 8'(i), 15'd0), 15'h7FFF);
    idle(2);
    check("sat_rx_count", 32'(s_rx_count), 32'd15);
    check("full_rx_count", 32'(rx_count), 32'd17);
    stat_sel = 3'd5;
    idle(1);
    check("sat_lat_sum", 32'(s_stat_out), 32'h0000FFFF);
    check("full_lat_sum", 32'(stat_out), 32'd557039);
    chk_stat("full_rx_stat", 3'd0, 24'd17);

    // asynchronous reset with flits in flight
    drive(mk(2'd1, 2'd1, 2'd2, 2'd2, 8'd0, 15'd0), 15'd0);
    drive(mk(2'd1, 2'd1, 2'd2, 2'd2, 8'd1, 15'd0), 15'd0);
    #3;
    reset = 1'b0;
    #1;
    check("arst_rx_count", 32'(rx_count), 32'd0);
    check("arst_stat_out", 32'(stat_out), 32'd0);
    check("arst_sat_rx", 32'(s_rx_count), 32'd0);
    #2;
    reset = 1'b1;
    for (int i = 0; i < 5; i++) begin
      idle(1);
      check("arst_no_pulse", 32'(rx_pulse), 32'd0);
    end
    check("arst_rx_after", 32'(rx_count), 32'd0);
    check("arst_last_src", 32'(last_src), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/local_sink.md
Name: local_sink

Overview:
- Ejection-side traffic sink. One instance sits on the local output port of each mesh router and consumes the flits that router delivers to its own node.
- It registers each arriving flit, decodes its header and checks it for routing, addressing and sequence errors.
- It measures network latency against the shared timestamp and keeps saturating statistics.
- The statistics are readable through a registered select port, giving the mesh-level testbench and FPGA wrapper per-node delivery counts and error flags.

Parameters:
- DATAWID, 32, flit width; the header layout below requires 32.
- MY_X, 0, column coordinate of this node (0..2).
- MY_Y, 0, row coordinate of this node (0..2).
- CNT_W, 16, width of event counters.
- SUM_W, 24, width of latency accumulator and stat_out.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- flit_in  in  DATAWID  router local output; sampled every cycle.
- time_now  in  15  shared free-running timestamp, same counter the injectors stamp from.
- en  in  1  statistics enable; when 0, flits are still pipelined but no counter or state updates.
- clr  in  1  synchronous clear of all statistics and sequence state.
- stat_sel  in  3  statistic select.
- stat_out  out  SUM_W  selected statistic, zero-extended, registered.
- rx_count  out  CNT_W  accepted-flit counter, direct.
- rx_pulse  out  1  one-cycle pulse per accepted flit.
- last_src  out  4  source index of the last accepted flit.
- err_flag  out  1  sticky OR of all error events.

Behaviour:
- Flit format: [31] valid, [30:29] dst_x, [28:27] dst_y, [26:25] src_x, [24:23] src_y, [22:15] seq (8b), [14:0] timestamp.
- src_idx = src_y*3 + src_x.
- Reset (reset=0, async): every register and output goes to 0, including all pipeline valids, counters, expected-seq table, seen bits and err_flag.
- Stage S0, cycle of arrival: register flit_in when bit 31 is set. Also register lat = (time_now - ts) mod 2^15, using the time_now of the same cycle.
- Stage S1, decode. Exactly one class is assigned:
  - bad_addr: src_x or src_y equals 3.
  - misroute: dst is not (MY_X, MY_Y).
  - good: otherwise.
- Stage S2, update; applies only when en=1.
  - Every class: err_flag is set for any non-good class or any seq error.
  - bad_addr: bad_addr_cnt increments.
  - misroute: misroute_cnt increments. Misrouted flits are not accepted.
  - good: rx_count increments, rx_pulse=1 and last_src is updated.
  - good, latency: lat_sum += lat; lat_max = max; lat_last = lat.
  - good, sequence: if seen[src] is 0, set seen and set exp[src] = seq+1. Otherwise, if seq != exp[src], seq_err_cnt increments; in all cases exp[src] <= seq+1 (resync), and 8-bit wrap 255->0 is legal.
- Latency: rx_pulse and rx_count change 3 cycles after flit_in arrival. Input-to-output is registered at every stage.
- Hazard: back-to-back good flits from the same source must forward the S2 exp/seen update into the S1 comparison. No seq error may appear from the pipeline gap.
- Saturation: all counters saturate at all-ones. lat_sum saturates at 2^SUM_W-1. Saturated counters do not wrap.
- clr: clr=1 zeroes counters, lat stats, seen, exp and err_flag on the next edge. It overrides any S2 update in the same cycle. In-flight pipeline flits are kept and update normally after clr drops.
- stat_sel mapping:
  - 0 rx_count
  - 1 misroute_cnt
  - 2 seq_err_cnt
  - 3 bad_addr_cnt
  - 4 lat_max
  - 5 lat_sum
  - 6 lat_last
  - 7 zero
- stat_out is updated one cycle after stat_sel and reflects counter values of the previous edge.
- Reset mid-traffic: the pipeline is flushed and no partial update occurs.

Test Plan:
- MY_X=1, MY_Y=1. Single flit 0xA8000010 (dst 1,1; src 0,0; seq 0; ts 0x10) with time_now=0x25 -> 3 cycles later rx_pulse=1, rx_count=1, last_src=0, lat_last=21, lat_max=21, err_flag=0.
- Four back-to-back flits from src (2,1) (idx 5) with seq 0,1,2,3 -> rx_count=4, seq_err_cnt=0, proving the forwarding path. Repeat with seq 0,1,3 -> seq_err_cnt=1 and err_flag=1; a following seq 4 produces no new error.
- Flit with dst (0,2) -> misroute_cnt=1, rx_count unchanged. Flit with src_x=3 -> bad_addr_cnt=1.
- Preload rx_count to 0xFFFE, then send 3 good flits -> rx_count holds 0xFFFF. Latency wrap: ts=0x7FF0, time_now=0x0005 -> lat_last=21.
- en=0 during 5 flits -> no stat change. Assert clr in the same cycle as an S2 update -> all stats 0 afterwards. Sweep stat_sel 0..7 and check the one-cycle read latency.
- Drive reset low asynchronously between clock edges while flits are in flight -> all outputs 0 immediately. After release, no stale rx_pulse appears.
